inst_mem_loader: RTL

- Boot-time writer for the word-addressed instruction memory.
- Takes a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Issues one write per word at byte addresses BASE_ADDR, BASE_ADDR+4, and so on.
- Holds the single-cycle MIPS core in reset (cpu_hold) until the full program is loaded.

---
 rtl/inst_mem_loader_if.sv | 29 ++
 rtl/inst_mem_loader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The loader uses the master modport (it consumes the stream and drives the
// memory write port); the stream source / memory side uses the slave modport.
interface inst_mem_loader_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_adr;
   logic [31:0] mem_wdata;

   modport master (
      input  in_valid,
      input  in_data,
      output in_ready,
      output mem_we,
      output mem_adr,
      output mem_wdata
   );

   modport slave (
      output in_valid,
      output in_data,
      input  in_ready,
      input  mem_we,
      input  mem_adr,
      input  mem_wdata
   );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory loader.
// Receives a 16-bit little-endian word count followed by that many
// little-endian 32-bit words as a byte stream, writes each word to
// consecutive word addresses starting at BASE_ADDR, and keeps the CPU in
// reset until the whole program has been written.
module inst_mem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 65536
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   inst_mem_loader_if.master  bus,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic               cpu_hold
);

   // Header count is at most 16 bits, so a 17-bit limit covers the default depth.
   localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] n_q, n_d;
   logic [16:0] idx_q, idx_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [31:0] word_q, word_d;

   logic        ready_c;
   logic        xfer;
   logic [16:0] n_full;
   logic [16:0] idx_inc;

   // The loader only accepts bytes while it is collecting the header or data.
   always_comb begin
      ready_c = 1'b0;
      case (state_q)
         S_LEN0, S_LEN1, S_DATA: ready_c = 1'b1;
         default:                ready_c = 1'b0;
      endcase
   end

   assign xfer    = bus.in_valid && ready_c;
   assign n_full  = {1'b0, bus.in_data, n_q[7:0]};
   assign idx_inc = idx_q + 17'd1;

   // State, header count, word index, byte lane and assembled word registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         idx_q   <= '0;
         bcnt_q  <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         bcnt_q  <= bcnt_d;
         word_q  <= word_d;
      end
   end

   // Next-state logic: header parse, byte-lane assembly and per-word write.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      idx_d   = idx_q;
      bcnt_d  = bcnt_q;
      word_d  = word_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LEN0;
               idx_d   = '0;
               bcnt_d  = '0;
            end
         end

         S_LEN0: begin
            if (xfer) begin
               n_d[7:0] = bus.in_data;
               state_d  = S_LEN1;
            end
         end

         S_LEN1: begin
            if (xfer) begin
               n_d[15:8] = bus.in_data;
               if (n_full == 17'd0) begin
                  state_d = S_DONE;
               end else if (n_full > MaxWords) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_DATA;
               end
            end
         end

         S_DATA: begin
            if (xfer) begin
               word_d[{bcnt_q, 3'b000} +: 8] = bus.in_data;
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end

         S_WRITE: begin
            // The write happens this cycle at the current index; the stream
            // is stalled by in_ready=0, so a waiting byte is held, not lost.
            idx_d = idx_inc;
            if (idx_inc == {1'b0, n_q}) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DATA;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Status and handshake outputs decoded from the current state.
   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      cpu_hold   = 1'b1;
      bus.mem_we = 1'b0;
      case (state_q)
         S_LEN0, S_LEN1, S_DATA: busy = 1'b1;
         S_WRITE: begin
            busy       = 1'b1;
            bus.mem_we = 1'b1;
         end
         S_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
         end
         S_ERR: error = 1'b1;
         default: ;
      endcase
   end

   assign bus.in_ready  = ready_c;
   // Address wraps modulo 2^32 when BASE_ADDR sits near the top of memory.
   assign bus.mem_adr   = BASE_ADDR + {13'd0, idx_q, 2'b00};
   assign bus.mem_wdata = word_q;

endmodule
